// File: rtl/keypad_if.sv
// Signal bundle between the keypad scanner/entry block and its consumer.
// master = keypad_entry side, slave = consumer/keypad side.
interface keypad_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [31:0] key_value;
  logic        key_finish;
  logic [3:0]  digit_count;
  logic        key_valid;
  logic [3:0]  key_code;

  modport master (
    input  row_in,
    output col_out, key_value, key_finish, digit_count, key_valid, key_code
  );

  modport slave (
    output row_in,
    input  col_out, key_value, key_finish, digit_count, key_valid, key_code
  );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with press/release debounce and a decimal entry accumulator.
// Optional sign key (C) enabled by defining KEYPAD_NEG_EN.
module keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 230000,
  parameter int MAX_DIGITS   = 9
) (
  input logic      clk,
  input logic      rst_n,
  keypad_if.master kp
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;
`ifdef KEYPAD_NEG_EN
  localparam logic [3:0] KEY_C    = 4'd11;
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t              state;
  logic [3:0]          row_meta, row_sync, row_lat;
  logic [3:0]          col_q;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic                key_valid_q;
  logic [3:0]          key_code_q;

  logic [31:0]         mag;
  logic [3:0]          count;
  logic                done;
  logic                neg;
  logic                key_finish_q;

  function automatic logic [1:0] first_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] cols);
    if (!cols[0])      return 2'd0;
    else if (!cols[1]) return 2'd1;
    else if (!cols[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  // Rows come straight from mechanical switches; two flops before any decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row_in;
      row_sync <= row_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      col_q       <= 4'b1110;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      row_lat     <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      key_valid_q <= 1'b0;
      unique case (state)
        SCAN: begin
          if (row_sync != 4'hF) begin
            row_lat <= row_sync;
            deb_cnt <= '0;
            state   <= DEBOUNCE;
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            col_q    <= {col_q[2:0], col_q[3]};
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          // Any deviation from the latched pattern (including release) is a bounce.
          if (row_sync != row_lat) begin
            scan_cnt <= '0;
            state    <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            key_valid_q <= 1'b1;
            key_code_q  <= {first_low(row_lat), col_idx(col_q)};
            state       <= PRESSED;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          deb_cnt <= '0;
          state   <= RELEASE;
        end
        RELEASE: begin
          if (row_sync != 4'hF) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            scan_cnt <= '0;
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  logic       is_digit;
  logic [3:0] digit;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    case (key_code_q)
      4'd0, 4'd1, 4'd2:  begin is_digit = 1'b1; digit = key_code_q + 4'd1; end
      4'd4, 4'd5, 4'd6:  begin is_digit = 1'b1; digit = key_code_q;        end
      4'd8, 4'd9, 4'd10: begin is_digit = 1'b1; digit = key_code_q - 4'd1; end
      4'd13:             begin is_digit = 1'b1; digit = 4'd0;              end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag          <= '0;
      count        <= '0;
      done         <= 1'b0;
      key_finish_q <= 1'b0;
    end else begin
      key_finish_q <= 1'b0;
      if (key_valid_q) begin
        if (is_digit) begin
          if (done) begin
            mag   <= 32'(digit);
            count <= 4'd1;
            done  <= 1'b0;
          end else if (count < 4'(MAX_DIGITS)) begin
            mag   <= mag * 32'd10 + 32'(digit);
            count <= count + 4'd1;
          end
        end else begin
          case (key_code_q)
            KEY_A: begin
              if (done) begin
                mag   <= '0;
                count <= '0;
                done  <= 1'b0;
              end else if (count != 4'd0) begin
                mag   <= mag / 32'd10;
                count <= count - 4'd1;
              end
            end
            KEY_STAR: begin
              mag   <= '0;
              count <= '0;
              done  <= 1'b0;
            end
            KEY_HASH: begin
              key_finish_q <= 1'b1;
              done         <= 1'b1;
            end
`ifdef KEYPAD_NEG_EN
            KEY_C: begin
              if (done) begin
                mag   <= '0;
                count <= '0;
                done  <= 1'b0;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

`ifdef KEYPAD_NEG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (key_valid_q) begin
      if (is_digit) begin
        if (done) neg <= 1'b0;
      end else begin
        case (key_code_q)
          KEY_A:    if (done) neg <= 1'b0;
          KEY_STAR: neg <= 1'b0;
          KEY_C:    neg <= done ? 1'b1 : ~neg;
          default: ;
        endcase
      end
    end
  end
`else
  assign neg = 1'b0;
`endif

  assign kp.col_out     = col_q;
  assign kp.key_value   = neg ? (32'd0 - mag) : mag;
  assign kp.key_finish  = key_finish_q;
  assign kp.digit_count = count;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_code    = key_code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a keypad model pulls a row low only while its column is driven.
module tb_keypad_entry;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_if kp ();

  keypad_entry #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8),
    .MAX_DIGITS  (9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  logic       pressed   = 1'b0;
  logic [3:0] row_pat   = 4'hF;
  logic [1:0] pcol      = 2'd0;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'hF;

  assign kp.row_in = force_en ? force_val :
                     (pressed && !kp.col_out[pcol]) ? row_pat : 4'hF;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_valid = 0;
  int          n_finish = 0;
  logic [31:0] fin_value = '0;

  always @(negedge clk) begin
    if (kp.key_valid) n_valid++;
    if (kp.key_finish) begin
      n_finish++;
      fin_value = kp.key_value;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input string tag);
    int v0;
    bit seen;
    v0      = n_valid;
    seen    = 1'b0;
    row_pat = ~(4'b0001 << code[3:2]);
    pcol    = code[1:0];
    pressed = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (n_valid != v0) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) check({tag, "_code"}, 32'(kp.key_code), 32'(code));
    repeat (20) @(negedge clk);
    pressed = 1'b0;
    repeat (25) @(negedge clk);
    check({tag, "_one_valid"}, 32'(n_valid - v0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int v0;
    logic [3:0] c0;
    bit moved;
    logic [31:0] neg_exp;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_col",    32'(kp.col_out),     32'h0000000E);
    check("rst_value",  kp.key_value,        32'd0);
    check("rst_finish", 32'(kp.key_finish),  32'd0);
    check("rst_count",  32'(kp.digit_count), 32'd0);
    check("rst_valid",  32'(kp.key_valid),   32'd0);
    check("rst_code",   32'(kp.key_code),    32'd0);
    repeat (4) @(negedge clk);
    check("scan_1101", 32'(kp.col_out), 32'h0000000D);
    repeat (4) @(negedge clk);
    check("scan_1011", 32'(kp.col_out), 32'h0000000B);
    repeat (4) @(negedge clk);
    check("scan_0111", 32'(kp.col_out), 32'h00000007);
    repeat (4) @(negedge clk);
    check("scan_wrap", 32'(kp.col_out), 32'h0000000E);

    // 1 2 3 #
    f0 = n_finish;
    press(4'd0,  "k1");
    press(4'd1,  "k2");
    press(4'd2,  "k3");
    check("val_12", kp.key_value, 32'd123);
    press(4'd14, "hash1");
    check("val_123",    kp.key_value,        32'd123);
    check("count_123",  32'(kp.digit_count), 32'd3);
    check("finish_123", 32'(n_finish - f0),  32'd1);
    check("finval_123", fin_value,           32'd123);

    // Bounce on row 0: shorter than the debounce window
    v0 = n_valid;
    force_val = 4'b1110;
    force_en  = 1'b1;
    repeat (5) @(negedge clk);
    force_en  = 1'b0;
    repeat (15) @(negedge clk);
    check("bounce_valid", 32'(n_valid - v0), 32'd0);
    check("bounce_value", kp.key_value,      32'd123);
    c0 = kp.col_out;
    moved = 1'b0;
    for (int i = 0; i < 10 && !moved; i++) begin
      @(negedge clk);
      if (kp.col_out != c0) moved = 1'b1;
    end
    check("bounce_scan", 32'(moved), 32'd1);

    // 4 5 A, then *, then A at zero digits
    press(4'd4, "k4");
    check("new_entry", kp.key_value, 32'd4);
    press(4'd5, "k5");
    press(4'd3, "bksp");
    check("bksp_value", kp.key_value,        32'd4);
    check("bksp_count", 32'(kp.digit_count), 32'd1);
    press(4'd12, "star");
    check("clr_value", kp.key_value,        32'd0);
    check("clr_count", 32'(kp.digit_count), 32'd0);
    press(4'd3, "bksp0");
    check("bksp0_value", kp.key_value,        32'd0);
    check("bksp0_count", 32'(kp.digit_count), 32'd0);

    // Ten nines: the tenth is dropped
    for (int i = 0; i < 10; i++) press(4'd10, "k9");
    check("max_value", kp.key_value,        32'd999999999);
    check("max_count", 32'(kp.digit_count), 32'd9);
    f0 = n_finish;
    press(4'd14, "hash2");
    check("finish_max", 32'(n_finish - f0), 32'd1);
    check("finval_max", fin_value,          32'd999999999);

    // 7 C # then 5
`ifdef KEYPAD_NEG_EN
    neg_exp = 32'hFFFFFFF9;
`else
    neg_exp = 32'd7;
`endif
    press(4'd8, "k7");
    check("k7_value", kp.key_value, 32'd7);
    press(4'd11, "keyc");
    check("sign_value", kp.key_value, neg_exp);
    f0 = n_finish;
    press(4'd14, "hash3");
    check("finish_sign", 32'(n_finish - f0), 32'd1);
    check("finval_sign", fin_value,          neg_exp);
    press(4'd5, "k5b");
    check("after_value", kp.key_value,        32'd5);
    check("after_count", 32'(kp.digit_count), 32'd1);
    check("finish_idle", 32'(kp.key_finish),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
